// File: rtl/cache_tester_if.sv
// CPU-side Cache port bundle: the tester drives the request side and the Cache
// returns read data, data-ready and busy.
interface cache_tester_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  write_enable;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;

  modport master (
    output address, data_in, write_enable,
    input  data_out, data_out_ready, busy
  );

  modport slave (
    input  address, data_in, write_enable,
    output data_out, data_out_ready, busy
  );
endinterface

// File: rtl/cache_tester.sv
// Memory-test sequencer for Cache bring-up. It writes an address-derived pattern
// to WORD_COUNT consecutive words, reads them back and compares. It reports
// pass/fail, the error count, the first failing address and a stall timeout.
module cache_tester #(
  parameter logic [31:0] START_ADDR     = 32'h0000_0000,
  parameter int unsigned WORD_COUNT     = 256,
  parameter logic [31:0] SEED           = 32'hA5A5_5A5A,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  cache_tester_if.master        io_cache,
  output logic                  o_running,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [15:0]           o_error_count,
  output logic [31:0]           o_first_error_address
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_ISSUE  = 3'd1,
    S_WR_WAIT   = 3'd2,
    S_RD_ISSUE  = 3'd3,
    S_RD_SETTLE = 3'd4,
    S_RD_WAIT   = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [15:0] LAST_IDX   = 16'(WORD_COUNT - 1);
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_state_next;
  logic [31:0] r_address, w_address_next;
  logic [31:0] r_data_in, w_data_in_next;
  logic [3:0]  r_we, w_we_next;
  logic        r_running, w_running_next;
  logic        r_done, w_done_next;
  logic        r_pass, w_pass_next;
  logic        r_timeout, w_timeout_next;
  logic [15:0] r_err, w_err_next;
  logic [31:0] r_first, w_first_next;
  logic [15:0] r_count, w_count_next;
  logic [31:0] r_timer, w_timer_next;
  logic        w_stall;

  // Expected word content for a given byte address.
  function automatic logic [31:0] pattern(input logic [31:0] addr);
    return addr ^ SEED;
  endfunction

  // Next-state and next-register values; every register defaults to its hold value.
  always_comb begin
    w_state_next   = r_state;
    w_address_next = r_address;
    w_data_in_next = r_data_in;
    w_we_next      = r_we;
    w_running_next = r_running;
    w_done_next    = r_done;
    w_pass_next    = r_pass;
    w_timeout_next = r_timeout;
    w_err_next     = r_err;
    w_first_next   = r_first;
    w_count_next   = r_count;
    w_timer_next   = 32'd0;
    w_stall        = 1'b0;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_next   = S_WR_ISSUE;
          w_address_next = START_ADDR;
          w_count_next   = 16'd0;
          w_err_next     = 16'd0;
          w_first_next   = 32'd0;
          w_timeout_next = 1'b0;
          w_pass_next    = 1'b0;
          w_done_next    = 1'b0;
          w_running_next = 1'b1;
          w_we_next      = 4'b0000;
        end else begin
          w_we_next = 4'b0000;
        end
      end
      S_WR_ISSUE: begin
        if (!io_cache.busy) begin
          w_data_in_next = pattern(r_address);
          w_we_next      = 4'b1111;
          w_state_next   = S_WR_WAIT;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_WR_WAIT: begin
        // The write strobe is presented for exactly one cycle.
        w_we_next = 4'b0000;
        if (!io_cache.busy) begin
          if (r_count == LAST_IDX) begin
            w_address_next = START_ADDR;
            w_count_next   = 16'd0;
            w_state_next   = S_RD_ISSUE;
          end else begin
            w_address_next = r_address + 32'd4;
            w_count_next   = r_count + 16'd1;
            w_state_next   = S_WR_ISSUE;
          end
        end else begin
          w_stall = 1'b1;
        end
      end
      S_RD_ISSUE: begin
        w_we_next = 4'b0000;
        if (!io_cache.busy) begin
          w_state_next = S_RD_SETTLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      S_RD_SETTLE: begin
        // Bubble so data_out_ready refers to the address now on the bus.
        w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (io_cache.data_out_ready && !io_cache.busy) begin
          if (io_cache.data_out != pattern(r_address)) begin
            if (r_err != 16'hFFFF) begin
              w_err_next = r_err + 16'd1;
            end else begin
              w_err_next = 16'hFFFF;
            end
            if (r_err == 16'd0) begin
              w_first_next = r_address;
            end else begin
              w_first_next = r_first;
            end
          end else begin
            w_err_next = r_err;
          end
          if (r_count == LAST_IDX) begin
            w_state_next   = S_DONE;
            w_running_next = 1'b0;
            w_done_next    = 1'b1;
            w_pass_next    = (w_err_next == 16'd0) && !r_timeout;
          end else begin
            w_address_next = r_address + 32'd4;
            w_count_next   = r_count + 16'd1;
            w_state_next   = S_RD_ISSUE;
          end
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // The per-access timer runs only while an access is stalled; it expiring aborts the test.
    if (w_stall) begin
      if (r_timer == TIMER_LAST) begin
        w_timeout_next = 1'b1;
        w_we_next      = 4'b0000;
        w_state_next   = S_DONE;
        w_running_next = 1'b0;
        w_done_next    = 1'b1;
        w_pass_next    = 1'b0;
        w_timer_next   = 32'd0;
      end else begin
        w_timer_next = r_timer + 32'd1;
      end
    end else begin
      w_timer_next = 32'd0;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_address <= START_ADDR;
      r_data_in <= 32'd0;
      r_we      <= 4'b0000;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 16'd0;
      r_first   <= 32'd0;
      r_count   <= 16'd0;
      r_timer   <= 32'd0;
    end else begin
      r_address <= w_address_next;
      r_data_in <= w_data_in_next;
      r_we      <= w_we_next;
      r_running <= w_running_next;
      r_done    <= w_done_next;
      r_pass    <= w_pass_next;
      r_timeout <= w_timeout_next;
      r_err     <= w_err_next;
      r_first   <= w_first_next;
      r_count   <= w_count_next;
      r_timer   <= w_timer_next;
    end
  end

  assign io_cache.address      = r_address;
  assign io_cache.data_in      = r_data_in;
  assign io_cache.write_enable = r_we;
  assign o_running             = r_running;
  assign o_done                = r_done;
  assign o_pass                = r_pass;
  assign o_timeout             = r_timeout;
  assign o_error_count         = r_err;
  assign o_first_error_address = r_first;

endmodule
